// File: rtl/mmm_pkg.sv
// Shared frontend definitions: datapath width, instruction size, recovery FSM states.
package mmm_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } frontend_ctrl_state_t;

endpackage

// File: rtl/outst_cnt.sv
// Up/down counter of in-flight i-cache requests, saturating at both ends.
module outst_cnt #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] next_cnt_o
);

  localparam logic [CNT_W-1:0] MaxC = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc/dec cancel; clamp at 0 and MAX_OUTST.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != MaxC)   cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign next_cnt_o = cnt_d;

  // A response with nothing in flight, or a request beyond capacity, is a protocol bug upstream.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && cnt_q == '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && cnt_q == MaxC));

endmodule

// File: rtl/frontend_flush_ctrl.sv
// Frontend recovery after a branch mispredict: flush, drain stale i-cache
// responses, then hand a single redirect PC to pc_gen.
module frontend_flush_ctrl
  import mmm_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1),
  parameter int PERF_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              res_valid_i,
  input  logic              res_mispredict_i,
  input  logic              res_taken_i,
  input  logic [XLEN-1:0]   res_pc_i,
  input  logic [XLEN-1:0]   res_target_i,
  input  logic              addr_valid_i,
  input  logic              addr_ready_i,
  input  logic              data_valid_i,
  input  logic              data_ready_i,
  input  logic              redirect_ready_i,
  output logic              fetch_en_o,
  output logic              flush_o,
  output logic              drop_resp_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] mispred_cnt_o
);

  localparam logic [CNT_W-1:0] MaxC = CNT_W'(MAX_OUTST);

  frontend_ctrl_state_t state_q;
  logic                 flush_q, drop_q, rvld_q;
  logic [XLEN-1:0]      rpc_q;
  logic [PERF_W-1:0]    mcnt_q;
  logic [CNT_W-1:0]     cnt, next_cnt;
  logic                 req_hs, rsp_hs, mispred;

  assign req_hs  = addr_valid_i & addr_ready_i;
  assign rsp_hs  = data_valid_i & data_ready_i;
  assign mispred = res_valid_i & res_mispredict_i;

  outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_outst (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (req_hs),
    .dec_i      (rsp_hs),
    .cnt_o      (cnt),
    .next_cnt_o (next_cnt)
  );

  // Recovery FSM; outputs are registered alongside the state they belong to.
  // Resolutions outside IDLE are wrong-path and never touch PC or perf count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      drop_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rpc_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (mispred) begin
          state_q <= FLUSH;
          flush_q <= 1'b1;
          drop_q  <= 1'b1;
          rpc_q   <= res_taken_i ? res_target_i : res_pc_i + XLEN'(INSTR_BYTES);
          if (mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;
        end
        FLUSH: begin
          flush_q <= 1'b0;
          if (next_cnt == '0) begin
            state_q <= REDIRECT;
            drop_q  <= 1'b0;
            rvld_q  <= 1'b1;
          end else begin
            state_q <= DRAIN;
          end
        end
        DRAIN: if (next_cnt == '0) begin
          state_q <= REDIRECT;
          drop_q  <= 1'b0;
          rvld_q  <= 1'b1;
        end
        REDIRECT: if (redirect_ready_i) begin
          state_q <= IDLE;
          rvld_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
          drop_q  <= 1'b0;
          rvld_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_en_o       = (state_q == IDLE) && (cnt < MaxC);
  assign flush_o          = flush_q;
  assign drop_resp_o      = drop_q;
  assign redirect_valid_o = rvld_q;
  assign redirect_pc_o    = rpc_q;
  assign busy_o           = (state_q != IDLE);
  assign mispred_cnt_o    = mcnt_q;

endmodule

// File: tb/tb_frontend_flush_ctrl.sv
// Scoreboard bench for frontend_flush_ctrl: stimulus queues cycle-stamped
// expectations and expected redirect PCs; a monitor checks them.
module tb_frontend_flush_ctrl;

  localparam int XL = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          res_valid_i, res_mispredict_i, res_taken_i;
  logic [XL-1:0] res_pc_i, res_target_i;
  logic          addr_valid_i, addr_ready_i, data_valid_i, data_ready_i;
  logic          redirect_ready_i;
  logic          fetch_en_o, flush_o, drop_resp_o, redirect_valid_o, busy_o;
  logic [XL-1:0] redirect_pc_o;
  logic [31:0]   mispred_cnt_o;

  frontend_flush_ctrl #(.MAX_OUTST(4), .PERF_W(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .res_valid_i      (res_valid_i),
    .res_mispredict_i (res_mispredict_i),
    .res_taken_i      (res_taken_i),
    .res_pc_i         (res_pc_i),
    .res_target_i     (res_target_i),
    .addr_valid_i     (addr_valid_i),
    .addr_ready_i     (addr_ready_i),
    .data_valid_i     (data_valid_i),
    .data_ready_i     (data_ready_i),
    .redirect_ready_i (redirect_ready_i),
    .fetch_en_o       (fetch_en_o),
    .flush_o          (flush_o),
    .drop_resp_o      (drop_resp_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int S_FEN = 0, S_FLUSH = 1, S_DROP = 2, S_RV = 3, S_PC = 4, S_BUSY = 5, S_MCNT = 6;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] v;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      S_FEN:   return 64'(fetch_en_o);
      S_FLUSH: return 64'(flush_o);
      S_DROP:  return 64'(drop_resp_o);
      S_RV:    return 64'(redirect_valid_o);
      S_PC:    return 64'(redirect_pc_o);
      S_BUSY:  return 64'(busy_o);
      default: return 64'(mispred_cnt_o);
    endcase
  endfunction

  // Monitor: cycle-stamped checks plus redirect-PC scoreboard on each redirect handshake.
  always @(negedge clk_i) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        tests++;
        if (pick(exp_q[i].sel) !== exp_q[i].v) begin
          fails++;
          $display("FAIL %s @cyc %0d: got %0h want %0h", exp_q[i].nm, cyc, pick(exp_q[i].sel), exp_q[i].v);
        end
        exp_q.delete(i);
      end
    end
    if (redirect_valid_o === 1'b1 && redirect_ready_i && !rst_i) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL redirect_unexpected @cyc %0d: got pc %0h want no redirect", cyc, redirect_pc_o);
      end else begin
        logic [31:0] e;
        e = rd_q.pop_front();
        if (redirect_pc_o !== e) begin
          fails++;
          $display("FAIL redirect_pc @cyc %0d: got %0h want %0h", cyc, redirect_pc_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic clr();
    res_valid_i = 0; res_mispredict_i = 0; res_taken_i = 0; res_pc_i = '0; res_target_i = '0;
    addr_valid_i = 0; addr_ready_i = 0; data_valid_i = 0; data_ready_i = 0;
    redirect_ready_i = 1;
  endtask

  task automatic mp(input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
    res_valid_i = 1; res_mispredict_i = 1; res_taken_i = tk; res_pc_i = pc; res_target_i = tgt;
  endtask

  task automatic req();
    addr_valid_i = 1; addr_ready_i = 1;
  endtask

  task automatic rsp();
    data_valid_i = 1; data_ready_i = 1;
  endtask

  task automatic chk(input int off, input int sel, input logic [63:0] v, input string nm);
    exp_q.push_back('{cyc + off, sel, v, nm});
  endtask

  task automatic chk_rst(input int off, input string nm);
    chk(off, S_FEN,   1, {nm, "_fen"});
    chk(off, S_FLUSH, 0, {nm, "_flush"});
    chk(off, S_DROP,  0, {nm, "_drop"});
    chk(off, S_RV,    0, {nm, "_rv"});
    chk(off, S_PC,    0, {nm, "_pc"});
    chk(off, S_BUSY,  0, {nm, "_busy"});
    chk(off, S_MCNT,  0, {nm, "_mcnt"});
  endtask

  initial begin
    clr();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    chk_rst(0, "reset");
    tick();

    // Taken mispredict, nothing outstanding: flush t+1, redirect t+2, fetch t+3.
    clr(); mp(1, 32'h0000_0500, 32'h0000_1000);
    rd_q.push_back(32'h0000_1000);
    chk(0, S_FEN, 1, "t1_fen_t0");
    chk(1, S_FLUSH, 1, "t1_flush_t1");
    chk(1, S_FEN, 0, "t1_fen_t1");
    chk(2, S_RV, 1, "t1_rv_t2");
    chk(2, S_FLUSH, 0, "t1_flush_t2");
    chk(2, S_FEN, 0, "t1_fen_t2");
    chk(3, S_FEN, 1, "t1_fen_t3");
    chk(3, S_BUSY, 0, "t1_busy_t3");
    chk(3, S_MCNT, 1, "t1_mcnt");
    tick(); clr(); tick(); tick(); tick();

    // Not-taken mispredict at top of address space: fall-through wraps to 0.
    clr(); mp(0, 32'hFFFF_FFFC, 32'h0000_1234);
    rd_q.push_back(32'h0000_0000);
    chk(3, S_MCNT, 2, "t2_mcnt");
    chk(3, S_FEN, 1, "t2_fen_t3");
    tick(); clr(); tick(); tick(); tick();

    // Fresh start, then drain two outstanding requests with wrong-path resolutions ignored.
    rst_i = 1; clr(); tick(); rst_i = 0;
    chk_rst(0, "rst2");
    req(); tick();
    for (int k = 0; k <= 12; k++) begin
      clr();
      case (k)
        0: begin
          req(); mp(1, 32'h0000_0500, 32'h0000_1000);
          rd_q.push_back(32'h0000_1000);
          chk(0, S_FEN, 1, "t3_fen_k0");
          chk(1, S_FLUSH, 1, "t3_flush_k1");
          chk(1, S_DROP, 1, "t3_drop_k1");
          chk(1, S_FEN, 0, "t3_fen_k1");
          chk(2, S_BUSY, 1, "t3_busy_k2");
          chk(2, S_FLUSH, 0, "t3_flush_k2");
          chk(2, S_DROP, 1, "t3_drop_k2");
          chk(2, S_RV, 0, "t3_rv_k2");
          chk(5, S_FEN, 0, "t3_fen_k5");
          chk(6, S_DROP, 1, "t3_drop_k6");
          chk(6, S_RV, 0, "t3_rv_k6");
          chk(7, S_RV, 1, "t3_rv_k7");
          chk(7, S_DROP, 0, "t3_drop_k7");
          chk(7, S_PC, 32'h1000, "t3_pc_k7");
          chk(10, S_RV, 1, "t3_rv_k10");
          chk(10, S_PC, 32'h1000, "t3_pc_k10");
          chk(10, S_MCNT, 1, "t3_mcnt_k10");
          chk(11, S_BUSY, 1, "t3_busy_k11");
          chk(11, S_FEN, 0, "t3_fen_k11");
          chk(12, S_FEN, 1, "t3_fen_k12");
          chk(12, S_BUSY, 0, "t3_busy_k12");
          chk(12, S_MCNT, 1, "t3_mcnt_k12");
          chk(12, S_PC, 32'h1000, "t3_pc_k12");
        end
        3:  mp(1, 32'h0000_0600, 32'h0000_2000);
        4:  rsp();
        6:  rsp();
        7:  redirect_ready_i = 0;
        8:  begin redirect_ready_i = 0; mp(1, 32'h0000_0700, 32'h0000_2000); end
        9:  redirect_ready_i = 0;
        10: redirect_ready_i = 0;
        default: ;
      endcase
      tick();
    end

    // Fill to capacity, concurrent req+rsp, then reset in the middle of a drain.
    for (int k = 0; k <= 15; k++) begin
      clr();
      rst_i = (k == 10);
      case (k)
        0: begin
          req();
          chk(3, S_FEN, 1, "t4_fen_cnt3");
          chk(4, S_FEN, 0, "t4_fen_cnt4");
          chk(5, S_FEN, 1, "t4_fen_cnt3b");
          chk(6, S_FEN, 1, "t4_fen_simul");
          chk(7, S_FEN, 0, "t4_fen_cnt4b");
          chk(8, S_FLUSH, 1, "t4_flush");
          chk(8, S_MCNT, 2, "t4_mcnt");
          chk(9, S_BUSY, 1, "t4_busy_drain");
          chk(9, S_DROP, 1, "t4_drop_drain");
          chk(9, S_FLUSH, 0, "t4_flush_drain");
          chk_rst(10, "t4_rst_now");
          chk_rst(11, "t4_rst_next");
          chk(14, S_FEN, 1, "t4_fen_post3");
          chk(15, S_FEN, 0, "t4_fen_post4");
        end
        1, 2, 3: req();
        4:  rsp();
        5:  begin req(); rsp(); end
        6:  req();
        7:  mp(1, 32'h0000_0800, 32'h0000_3000);
        11, 12, 13, 14: req();
        default: ;
      endcase
      tick();
    end
    clr();
    tick(); tick();

    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover: got %0d checks and %0d redirects pending want 0", exp_q.size(), rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frontend_flush_ctrl.md
Name: frontend_flush_ctrl

Overview:
- Sequences frontend recovery after a branch misprediction.
- Tracks outstanding i-cache fetch requests and gates new requests.
- On misprediction: flushes the fetch stage, drops stale i-cache responses until none are in flight, then issues a single redirect to the PC-gen stage.
- Sits between the branch unit (ex stage), fetch_stage, the i-cache handshake and pc_gen_stage.

Parameters:
- MAX_OUTST, 4: maximum i-cache requests in flight (≥1).
- CNT_W, $clog2(MAX_OUTST+1): width of the outstanding counter.
- PERF_W, 32: width of the mispredict event counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- res_valid_i  in  1  branch resolution valid
- res_mispredict_i  in  1  resolved branch was mispredicted
- res_taken_i  in  1  resolved direction
- res_pc_i  in  XLEN  PC of resolved branch
- res_target_i  in  XLEN  resolved taken target
- addr_valid_i  in  1  fetch→i-cache request valid (snooped)
- addr_ready_i  in  1  i-cache request ready (snooped)
- data_valid_i  in  1  i-cache response valid (snooped)
- data_ready_i  in  1  fetch response ready (snooped)
- redirect_ready_i  in  1  pc_gen accepts redirect
- fetch_en_o  out  1  fetch may assert addr_valid
- flush_o  out  1  flush fetch stage / issue queue
- drop_resp_o  out  1  fetch must discard accepted responses
- redirect_valid_o  out  1  redirect PC valid
- redirect_pc_o  out  XLEN  redirect PC
- busy_o  out  1  state != IDLE
- mispred_cnt_o  out  PERF_W  saturating count of accepted mispredicts

Behaviour:
- Reset values: state IDLE, counter 0, fetch_en_o=1, flush_o=0, drop_resp_o=0, redirect_valid_o=0, redirect_pc_o=0, busy_o=0, mispred_cnt_o=0.
- Events:
  - Request handshake = addr_valid_i & addr_ready_i.
  - Response handshake = data_valid_i & data_ready_i.
  - Mispredict = res_valid_i & res_mispredict_i.
- Outstanding counter:
  - +1 on request handshake, −1 on response handshake; both in the same cycle → unchanged.
  - Response handshake at count 0 → count stays 0; a simulation assertion fires.
  - Request handshake at count MAX_OUTST → assertion; the count saturates.
- fetch_en_o = (state==IDLE) & (count<MAX_OUTST). It is combinational from registered state and count.
- States:
  - IDLE: no flush/drop/redirect.
    - Mispredict → FLUSH.
    - Latch redirect_pc = res_taken_i ? res_target_i : res_pc_i+4 (mod 2^XLEN wrap).
    - mispred_cnt +1, saturating at all-ones.
  - FLUSH (exactly 1 cycle): flush_o=1, drop_resp_o=1, fetch_en_o=0.
    - next_count==0 → REDIRECT; else → DRAIN.
  - DRAIN: drop_resp_o=1, fetch_en_o=0. Stay until next_count==0, then → REDIRECT. A response handshake in the cycle the count goes 1→0 also exits.
  - REDIRECT: redirect_valid_o=1, drop_resp_o=0, fetch_en_o=0. redirect_pc_o is held stable.
    - redirect_ready_i=1 → IDLE; fetch_en_o returns the next cycle.
- Latency: with no requests outstanding and redirect_ready_i tied 1:
  - mispredict at cycle t;
  - flush_o at t+1;
  - redirect_valid_o at t+2;
  - fetch_en_o at t+3.
- A request accepted in the same cycle the mispredict is seen (IDLE) is counted and drained.
- Resolutions (mispredicted or not) arriving in any non-IDLE state are wrong-path and ignored. They change neither the latched PC nor the perf counter.
- res_valid_i without res_mispredict_i has no effect.
- rst_i asserted mid-sequence: immediate return to reset values; any in-flight redirect is abandoned.

Decomposition:
- mmm_pkg gains:
  - INSTR_BYTES=4, used for the fall-through PC;
  - frontend_ctrl_state_t enum {IDLE, FLUSH, DRAIN, REDIRECT}.
- XLEN comes from mmm_pkg.
- Sub-module outst_cnt:
  - parameterised up/down counter with saturation and assertions;
  - ports inc_i, dec_i, cnt_o, next_cnt_o.

Test Plan:
- Idle, count 0; mispredict, taken, target 0x0000_1000 at cycle t, redirect_ready=1 → flush_o at t+1, redirect_valid_o=1 with pc 0x1000 at t+2, fetch_en_o=1 at t+3, mispred_cnt_o=1.
- Not-taken mispredict, res_pc 0xFFFF_FFFC → redirect_pc_o=0x0000_0000 (wrap).
- Two requests accepted before the mispredict; responses return 3 and 5 cycles after the flush → DRAIN with drop_resp_o=1 until the second response, REDIRECT the next cycle, no addr handshakes meanwhile.
- Count at MAX_OUTST=4 → fetch_en_o=0. Simultaneous request+response handshakes → count unchanged at 3.
- A second mispredict (target 0x2000) during DRAIN and REDIRECT → ignored; redirect_pc_o stays 0x1000 and mispred_cnt_o stays 1. redirect_ready_i held 0 for 4 cycles → redirect_valid_o and redirect_pc_o held stable.
- rst_i asserted during DRAIN → next cycle all outputs at reset values, count 0, state IDLE.
